// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg
//   Elastic valid/ready pipeline register placed at a processor stage boundary.
//   It carries an opaque DATA_W payload. It has an optional skid entry, so it
//   can stream at full rate while in_ready stays registered.
//
//   Flush is synchronous. It squashes every held entry and any beat accepted
//   in the same cycle. A beat that fires in the flush cycle still belongs to
//   the downstream stage.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    upstream has a payload
//   in_ready    this register can accept this cycle
//               (registered when SKID=1, combinational when SKID=0)
//   in_data     upstream payload
//   flush       squash all held entries
//   out_valid   main entry holds a valid payload
//   out_ready   downstream consumes this cycle
//   out_data    main entry payload
//   push_done   1-cycle pulse: a beat was accepted in the previous cycle
//   occupancy   number of valid entries (0..2)
//   drop_count  saturating count of entries discarded by flush
module pipe_elastic_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              push_done,
  output logic [1:0]        occupancy,
  output logic [DROP_W-1:0] drop_count
);

  // One extra bit holds the unsaturated sum (at most 2^DROP_W + 1).
  localparam logic [DROP_W:0] DROP_MAX = {1'b0, {DROP_W{1'b1}}};

  logic              main_valid_r, main_valid_s;
  logic              skid_valid_r, skid_valid_s;
  logic [DATA_W-1:0] main_data_r,  main_data_s;
  logic [DATA_W-1:0] skid_data_r,  skid_data_s;
  logic              in_ready_r;
  logic              push_done_r;
  logic [1:0]        occupancy_r;
  logic [DROP_W-1:0] drop_count_r, drop_count_s;
  logic [1:0]        drops_s;
  logic [DROP_W:0]   drop_sum_s;
  logic              acc_s;
  logic              fire_s;
  logic              in_ready_s;

  // With a skid entry, ready is a flop and depends only on skid occupancy.
  // Without one, ready must look through to out_ready to avoid a bubble.
  assign in_ready_s = (SKID != 0) ? in_ready_r : (!main_valid_r || out_ready);
  assign acc_s      = in_valid && in_ready_s;
  assign fire_s     = main_valid_r && out_ready;

  assign in_ready   = in_ready_s;
  assign out_valid  = main_valid_r;
  assign out_data   = main_data_r;
  assign push_done  = push_done_r;
  assign occupancy  = occupancy_r;
  assign drop_count = drop_count_r;

  // Next-state selection for the main/skid entries and the per-cycle drop tally.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    drops_s      = 2'd0;
    if (flush) begin
      // A main entry that fires now is downstream's, so it is not counted as dropped.
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
      drops_s      = {1'b0, main_valid_r && !fire_s} + {1'b0, skid_valid_r} + {1'b0, acc_s};
    end else if (SKID != 0) begin
      if (skid_valid_r) begin
        // in_ready is low while skid is full, so no accept can coincide here.
        if (fire_s) begin
          main_data_s  = skid_data_r;
          skid_valid_s = 1'b0;
        end else begin
          main_data_s  = main_data_r;
        end
      end else if (acc_s) begin
        if (!main_valid_r || fire_s) begin
          main_data_s  = in_data;
          main_valid_s = 1'b1;
        end else begin
          skid_data_s  = in_data;
          skid_valid_s = 1'b1;
        end
      end else if (fire_s) begin
        main_valid_s = 1'b0;
      end else begin
        main_valid_s = main_valid_r;
      end
    end else begin
      if (acc_s) begin
        main_data_s  = in_data;
        main_valid_s = 1'b1;
      end else if (fire_s) begin
        main_valid_s = 1'b0;
      end else begin
        main_valid_s = main_valid_r;
      end
    end
  end

  // Saturating accumulation of flush drops.
  always_comb begin
    drop_sum_s = {1'b0, drop_count_r} + (DROP_W + 1)'(drops_s);
    if (drop_sum_s > DROP_MAX) begin
      drop_count_s = DROP_MAX[DROP_W-1:0];
    end else begin
      drop_count_s = drop_sum_s[DROP_W-1:0];
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_data_r  <= '0;
      skid_data_r  <= '0;
      in_ready_r   <= 1'b1;
      push_done_r  <= 1'b0;
      occupancy_r  <= 2'd0;
      drop_count_r <= '0;
    end else begin
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      main_data_r  <= main_data_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= !skid_valid_s;
      push_done_r  <= acc_s && !flush;
      occupancy_r  <= {1'b0, main_valid_s} + {1'b0, skid_valid_s};
      drop_count_r <= drop_count_s;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg
//   Directed bench for pipe_elastic_reg.
//   u0 is a SKID=1 instance with a 2-bit drop counter, so saturation is
//   reachable. u1 is a SKID=0 instance.
//   Each instance has a queue-based reference model that is compared every
//   negative clock edge. Directed checks with literal values pin the model.
module tb_pipe_elastic_reg;

  logic        clk;
  logic        reset;
  logic        iv0, ir0, fl0, ov0, or0, pd0;
  logic [15:0] d0, od0;
  logic [1:0]  oc0;
  logic [1:0]  dc0;
  logic        iv1, ir1, fl1, ov1, or1, pd1;
  logic [15:0] d1, od1;
  logic [1:0]  oc1;
  logic [7:0]  dc1;

  int total;
  int bad;

  // Reference model state: the queue holds the valid entries, head first.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          md0, md1;
  logic        mp0, mp1;
  bit          a0, f0, a1, f1;
  int          n0, n1;

  pipe_elastic_reg #(.DATA_W(16), .SKID(1), .DROP_W(2)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0), .flush(fl0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .push_done(pd0), .occupancy(oc0), .drop_count(dc0)
  );

  pipe_elastic_reg #(.DATA_W(16), .SKID(0), .DROP_W(8)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(iv1), .in_ready(ir1), .in_data(d1), .flush(fl1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .push_done(pd1), .occupancy(oc1), .drop_count(dc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [15:0] d, input logic f, input logic r);
    iv0 = v; d0 = d; fl0 = f; or0 = r;
  endtask

  task automatic drv1(input logic v, input logic [15:0] d, input logic f, input logic r);
    iv1 = v; d1 = d; fl1 = f; or1 = r;
  endtask

  // Compare against the model, then advance the model with the inputs
  // that will be sampled at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        q0.delete(); q1.delete();
        md0 = 0; md1 = 0; mp0 = 1'b0; mp1 = 1'b0;
      end
      chk("m0 out_valid", 32'(ov0), 32'(q0.size() > 0));
      chk("m0 in_ready",  32'(ir0), 32'(q0.size() < 2));
      chk("m0 occupancy", 32'(oc0), 32'(q0.size()));
      chk("m0 push_done", 32'(pd0), 32'(mp0));
      chk("m0 drop_count", 32'(dc0), 32'(md0));
      if (q0.size() > 0) chk("m0 out_data", 32'(od0), 32'(q0[0]));
      chk("m1 out_valid", 32'(ov1), 32'(q1.size() > 0));
      chk("m1 in_ready",  32'(ir1), 32'(q1.size() == 0 || or1));
      chk("m1 occupancy", 32'(oc1), 32'(q1.size()));
      chk("m1 push_done", 32'(pd1), 32'(mp1));
      chk("m1 drop_count", 32'(dc1), 32'(md1));
      if (q1.size() > 0) chk("m1 out_data", 32'(od1), 32'(q1[0]));
      if (!reset) begin
        a0 = iv0 && (q0.size() < 2);
        f0 = (q0.size() > 0) && or0;
        if (f0) void'(q0.pop_front());
        if (fl0) begin
          n0 = int'(q0.size()) + (a0 ? 1 : 0);
          q0.delete();
          md0 = (md0 + n0 > 3) ? 3 : md0 + n0;
        end else if (a0) begin
          q0.push_back(d0);
        end
        mp0 = a0 && !fl0;

        a1 = iv1 && (q1.size() == 0 || or1);
        f1 = (q1.size() > 0) && or1;
        if (f1) void'(q1.pop_front());
        if (fl1) begin
          n1 = int'(q1.size()) + (a1 ? 1 : 0);
          q1.delete();
          md1 = (md1 + n1 > 255) ? 255 : md1 + n1;
        end else if (a1) begin
          q1.push_back(d1);
        end
        mp1 = a1 && !fl1;
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drv0(1'b0, 16'h0000, 1'b0, 1'b0);
    drv1(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(ov0), 32'd0);
    chk("rst out_data",  32'(od0), 32'd0);
    chk("rst in_ready",  32'(ir0), 32'd1);
    chk("rst occupancy", 32'(oc0), 32'd0);
    chk("rst drop",      32'(dc0), 32'd0);
    chk("rst push_done", 32'(pd0), 32'd0);
    reset = 1'b0;

    // Streaming: each beat appears one cycle after it is accepted.
    drv0(1'b1, 16'h0001, 1'b0, 1'b1); tick();
    chk("s1 data", 32'(od0), 32'h1);
    chk("s1 push", 32'(pd0), 32'd1);
    drv0(1'b1, 16'h0002, 1'b0, 1'b1); tick();
    chk("s2 data", 32'(od0), 32'h2);
    drv0(1'b1, 16'h0003, 1'b0, 1'b1); tick();
    chk("s3 data", 32'(od0), 32'h3);
    chk("s3 occ",  32'(oc0), 32'd1);
    drv0(1'b0, 16'h0000, 1'b0, 1'b1); tick();
    chk("s drain valid", 32'(ov0), 32'd0);
    chk("s drain push",  32'(pd0), 32'd0);

    // Backpressure: B lands in skid, then A and B drain in order.
    drv0(1'b1, 16'h00AA, 1'b0, 1'b0); tick();
    chk("bp A data", 32'(od0), 32'hAA);
    drv0(1'b1, 16'h00BB, 1'b0, 1'b0); tick();
    chk("bp occ2",   32'(oc0), 32'd2);
    chk("bp ready0", 32'(ir0), 32'd0);
    chk("bp A hold", 32'(od0), 32'hAA);
    drv0(1'b0, 16'h0000, 1'b0, 1'b1); tick();
    chk("bp B data", 32'(od0), 32'hBB);
    chk("bp ready1", 32'(ir0), 32'd1);
    tick();
    chk("bp empty",  32'(oc0), 32'd0);

    // Flush with both entries full: in_ready is low, so two entries drop.
    drv0(1'b1, 16'h0011, 1'b0, 1'b0); tick();
    drv0(1'b1, 16'h0012, 1'b0, 1'b0); tick();
    drv0(1'b1, 16'h0013, 1'b1, 1'b0); tick();
    chk("fl valid", 32'(ov0), 32'd0);
    chk("fl occ",   32'(oc0), 32'd0);
    chk("fl drop",  32'(dc0), 32'd2);
    chk("fl push",  32'(pd0), 32'd0);

    // Flush while the main entry fires: nothing is dropped.
    drv0(1'b1, 16'h0021, 1'b0, 1'b0); tick();
    drv0(1'b0, 16'h0000, 1'b1, 1'b1); tick();
    chk("ff occ",  32'(oc0), 32'd0);
    chk("ff drop", 32'(dc0), 32'd2);

    // Main entry plus a concurrent accept dropped: 2 + 2 saturates at 3.
    drv0(1'b1, 16'h0014, 1'b0, 1'b0); tick();
    drv0(1'b1, 16'h0015, 1'b1, 1'b0); tick();
    chk("sat drop", 32'(dc0), 32'd3);
    chk("sat push", 32'(pd0), 32'd0);
    drv0(1'b1, 16'h0016, 1'b0, 1'b0); tick();
    drv0(1'b0, 16'h0000, 1'b1, 1'b0); tick();
    chk("sat hold", 32'(dc0), 32'd3);

    // Async reset between edges while stalled with two entries held.
    drv0(1'b1, 16'h0031, 1'b0, 1'b0); tick();
    drv0(1'b1, 16'h0032, 1'b0, 1'b0); tick();
    drv0(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar valid", 32'(ov0), 32'd0);
    chk("ar occ",   32'(oc0), 32'd0);
    chk("ar drop",  32'(dc0), 32'd0);
    chk("ar ready", 32'(ir0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("ar push",  32'(pd0), 32'd0);

    // SKID=0: ready follows out_ready when full; accept and fire pass through.
    drv1(1'b1, 16'h0041, 1'b0, 1'b0); #1;
    chk("k0 ready empty", 32'(ir1), 32'd1);
    tick();
    chk("k0 data", 32'(od1), 32'h41);
    chk("k0 push", 32'(pd1), 32'd1);
    drv1(1'b1, 16'h0042, 1'b0, 1'b0); #1;
    chk("k0 ready full", 32'(ir1), 32'd0);
    tick();
    chk("k0 hold", 32'(od1), 32'h41);
    chk("k0 nopush", 32'(pd1), 32'd0);
    drv1(1'b1, 16'h0042, 1'b0, 1'b1); #1;
    chk("k0 ready thru", 32'(ir1), 32'd1);
    tick();
    chk("k0 pass data", 32'(od1), 32'h42);
    chk("k0 pass occ",  32'(oc1), 32'd1);
    drv1(1'b1, 16'h0043, 1'b0, 1'b0); tick();
    drv1(1'b1, 16'h0044, 1'b1, 1'b1); tick();
    chk("k0 fl drop",  32'(dc1), 32'd1);
    chk("k0 fl valid", 32'(ov1), 32'd0);
    drv1(1'b0, 16'h0000, 1'b0, 1'b0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
